count_job_scheduler: RTL

Upstream job feeder for the counter controller. Buffers count requests (length + tag) from a producer in a small FIFO, issues them one at a time to the controller as a one-cycle `start_o` with `cnt_val_o`, waits for the controller's `done_i`, then returns a tagged response under valid/ready handshake. It serialises back-to-back jobs and filters zero-length jobs that the controller cannot terminate.

---
 rtl/count_pkg.sv | 18 +
 rtl/count_req_fifo.sv | 47 ++++
 rtl/count_job_scheduler.sv | 102 ++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared constants and FSM encoding for the count job scheduler
package count_pkg;

  localparam int COUNT_DWIDTH = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP
  } sched_state_e;

endpackage

// File: rtl/count_req_fifo.sv
// rtl/count_req_fifo.sv - request FIFO, extra-bit pointers, registered-only outputs
module count_req_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged before any same-cycle pop, so a full FIFO never accepts.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level_o = wr_ptr - rd_ptr;
  assign rdata_o = mem[rd_ptr[AW-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/count_job_scheduler.sv
// rtl/count_job_scheduler.sv - queues count jobs, issues them to the controller, returns tagged responses
module count_job_scheduler
  import count_pkg::*;
#(
  parameter int DWIDTH = COUNT_DWIDTH,
  parameter int TAGW   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [DWIDTH-1:0]        req_len_i,
  input  logic [TAGW-1:0]          req_tag_i,
  output logic                     start_o,
  output logic [DWIDTH-1:0]        cnt_val_o,
  input  logic                     run_i,
  input  logic                     done_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [TAGW-1:0]          rsp_tag_o,
  output logic                     rsp_err_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o
);

  localparam int FW = DWIDTH + TAGW;

  sched_state_e      state;
  logic [DWIDTH-1:0] job_len;
  logic [TAGW-1:0]   job_tag;
  logic              job_err;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [FW-1:0]     fifo_rdata;
  logic [DWIDTH-1:0] head_len;
  logic [TAGW-1:0]   head_tag;

  assign head_len = fifo_rdata[FW-1:TAGW];
  assign head_tag = fifo_rdata[TAGW-1:0];
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  count_req_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid_i && !fifo_full),
    .wdata_i ({req_len_i, req_tag_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // Zero-length jobs would never terminate in the controller, so they skip straight to an error response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      job_len <= '0;
      job_tag <= '0;
      job_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            job_len <= head_len;
            job_tag <= head_tag;
            if (head_len == '0) begin
              job_err <= 1'b1;
              state   <= ST_RESP;
            end else begin
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT:  if (done_i) state <= ST_RESP;
        ST_RESP: begin
          if (rsp_ready_i) begin
            job_err <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = !fifo_full;
  assign start_o     = (state == ST_ISSUE);
  assign cnt_val_o   = job_len;
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_tag_o   = job_tag;
  assign rsp_err_o   = job_err;
  assign busy_o      = (state != ST_IDLE) || run_i;

endmodule
